// File: rtl/monopulse_scheduler.sv
// Monopulse relation scheduler: round-robin sharing of one |err|*|ref| datapath
// between N_CH requesters. Each grant is tagged with the requester id. Results
// land in a credit-protected, fall-through result FIFO with a valid/ready output.

// Guards the result FIFO against a write into a full buffer with no pop.
module monopulse_scheduler_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input logic             i_clock,
  input logic             i_reset,
  input logic [CNT_W-1:0] i_count,
  input logic             i_store,
  input logic             i_remove
);

  // Flags any store into a full FIFO that is not matched by a removal.
  always @(posedge i_clock) begin
    if (!i_reset) begin
      assert (!(i_store && !i_remove && (i_count == CNT_W'(FIFO_DEPTH))));
    end
  end

endmodule

module monopulse_scheduler #(
  parameter int DATA_SIZE  = 64,
  parameter int N_CH       = 4,
  parameter int MP_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = $clog2(N_CH)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic [N_CH-1:0]           i_req,
  input  logic [N_CH*DATA_SIZE-1:0] i_reference,
  input  logic [N_CH*DATA_SIZE-1:0] i_error,
  output logic [N_CH-1:0]           o_grant,
  output logic                      o_mp_reset,
  output logic [DATA_SIZE-1:0]      o_mp_reference,
  output logic [DATA_SIZE-1:0]      o_mp_error,
  input  logic [DATA_SIZE-1:0]      i_mp_relation,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic [DATA_SIZE-1:0]      o_res_data,
  output logic [ID_W-1:0]           o_res_id,
  output logic                      o_busy
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int STAGES = MP_LATENCY + 1;

  // Wraps a FIFO pointer at FIFO_DEPTH (depth need not fill the pointer range).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  logic                 clear_s;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      cand_s;
  logic                 grant_any_s;
  logic [ID_W-1:0]      grant_id_s;
  logic                 credit_ok_s;
  logic [CNT_W:0]       occupancy_s;

  logic [STAGES-1:0]    tag_valid_q;
  logic [ID_W-1:0]      tag_id_q [STAGES];
  logic                 exit_s;
  logic                 push_s;

  logic [CNT_W-1:0]     in_flight_q, in_flight_d;
  logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [DATA_SIZE-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ID_W-1:0]      fifo_id_q [FIFO_DEPTH];
  logic                 fifo_empty_s;
  logic                 res_valid_s;
  logic                 pop_s;
  logic                 store_s;
  logic                 remove_s;
  logic [DATA_SIZE-1:0] head_data_s;
  logic [ID_W-1:0]      head_id_s;

  assign clear_s      = i_reset | i_flush;
  assign o_mp_reset   = clear_s;

  // Credit uses occupancy before this cycle's pop, so a granted result always has a slot.
  assign occupancy_s  = {1'b0, in_flight_q} + {1'b0, fifo_count_q};
  assign credit_ok_s  = occupancy_s < (CNT_W + 1)'(FIFO_DEPTH);

  assign exit_s       = tag_valid_q[STAGES-1];
  assign push_s       = exit_s & ~clear_s;
  assign fifo_empty_s = (fifo_count_q == '0);

  // Round-robin search from the pointer upward with wrap; first requester wins.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = '0;
    cand_s      = '0;
    if (!clear_s && credit_ok_s) begin
      for (int i = 0; i < N_CH; i++) begin
        cand_s = ID_W'((int'(rr_ptr_q) + i) % N_CH);
        if (!grant_any_s && i_req[cand_s]) begin
          grant_any_s = 1'b1;
          grant_id_s  = cand_s;
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
  end

  // One-hot grant decode and pointer advance past the winner.
  always_comb begin
    o_grant  = '0;
    rr_ptr_d = rr_ptr_q;
    if (grant_any_s) begin
      o_grant[grant_id_s] = 1'b1;
      if (grant_id_s == ID_W'(N_CH - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_id_s + 1'b1;
      end
    end else begin
      o_grant  = '0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // In-flight tag count: +1 per grant, -1 per tag leaving the pipe.
  always_comb begin
    in_flight_d = in_flight_q;
    if (grant_any_s && !exit_s) begin
      in_flight_d = in_flight_q + 1'b1;
    end else if (!grant_any_s && exit_s) begin
      in_flight_d = in_flight_q - 1'b1;
    end else begin
      in_flight_d = in_flight_q;
    end
  end

  // Fall-through head: an empty FIFO presents the result arriving this cycle.
  always_comb begin
    head_data_s = '0;
    head_id_s   = '0;
    if (!fifo_empty_s) begin
      head_data_s = fifo_data_q[rd_ptr_q];
      head_id_s   = fifo_id_q[rd_ptr_q];
    end else if (push_s) begin
      head_data_s = i_mp_relation;
      head_id_s   = tag_id_q[STAGES-1];
    end else begin
      head_data_s = '0;
      head_id_s   = '0;
    end
  end

  assign res_valid_s = (~fifo_empty_s | push_s) & ~clear_s;
  assign pop_s       = res_valid_s & i_res_ready;
  // A result popped in the same cycle it arrives at an empty FIFO is never stored.
  assign store_s     = push_s & ~(pop_s & fifo_empty_s);
  assign remove_s    = pop_s & ~fifo_empty_s;

  assign o_res_valid = res_valid_s;
  assign o_res_data  = res_valid_s ? head_data_s : '0;
  assign o_res_id    = res_valid_s ? head_id_s : '0;
  assign o_busy      = ~clear_s & ((in_flight_q != '0) | ~fifo_empty_s);

  // FIFO occupancy update from store/remove.
  always_comb begin
    fifo_count_d = fifo_count_q;
    if (store_s && !remove_s) begin
      fifo_count_d = fifo_count_q + 1'b1;
    end else if (!store_s && remove_s) begin
      fifo_count_d = fifo_count_q - 1'b1;
    end else begin
      fifo_count_d = fifo_count_q;
    end
  end

  // Round-robin pointer: cleared by reset only, untouched by flush.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Operand issue registers toward the datapath; hold when nothing is granted.
  always_ff @(posedge i_clock) begin
    if (clear_s) begin
      o_mp_reference <= '0;
      o_mp_error     <= '0;
    end else if (grant_any_s) begin
      o_mp_reference <= i_reference[grant_id_s*DATA_SIZE +: DATA_SIZE];
      o_mp_error     <= i_error[grant_id_s*DATA_SIZE +: DATA_SIZE];
    end else begin
      o_mp_reference <= o_mp_reference;
      o_mp_error     <= o_mp_error;
    end
  end

  // Tag pipe tracking {valid,id} alongside the datapath latency.
  always_ff @(posedge i_clock) begin
    if (clear_s) begin
      tag_valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      tag_valid_q <= {tag_valid_q[STAGES-2:0], grant_any_s};
      tag_id_q[0] <= grant_id_s;
      for (int s = 1; s < STAGES; s++) begin
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  // Occupancy counters and FIFO pointers; reset and flush both empty everything.
  always_ff @(posedge i_clock) begin
    if (clear_s) begin
      in_flight_q  <= '0;
      fifo_count_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      in_flight_q  <= in_flight_d;
      fifo_count_q <= fifo_count_d;
      rd_ptr_q     <= remove_s ? ptr_next(rd_ptr_q) : rd_ptr_q;
      wr_ptr_q     <= store_s ? ptr_next(wr_ptr_q) : wr_ptr_q;
    end
  end

  // FIFO storage; contents are only meaningful behind a valid count.
  always_ff @(posedge i_clock) begin
    if (store_s) begin
      fifo_data_q[wr_ptr_q] <= i_mp_relation;
      fifo_id_q[wr_ptr_q]   <= tag_id_q[STAGES-1];
    end
  end

  monopulse_scheduler_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_chk (
    .i_clock  (i_clock),
    .i_reset  (clear_s),
    .i_count  (fifo_count_q),
    .i_store  (store_s),
    .i_remove (remove_s)
  );

endmodule

// File: tb/tb_monopulse_scheduler.sv
// Directed bench for monopulse_scheduler with a 2-stage |err|*|ref| datapath model.
module tb_monopulse_scheduler;

  localparam int DS = 64;
  localparam int NC = 4;

  logic             clk = 1'b0;
  logic             i_reset, i_flush;
  logic [NC-1:0]    i_req;
  logic [NC*DS-1:0] i_reference, i_error;
  logic [NC-1:0]    o_grant;
  logic             o_mp_reset;
  logic [DS-1:0]    o_mp_reference, o_mp_error;
  logic [DS-1:0]    i_mp_relation;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [DS-1:0]    o_res_data;
  logic [1:0]       o_res_id;
  logic             o_busy;

  logic [DS-1:0]    dp1, dp2;
  logic [DS-1:0]    prod [4];
  int               passed = 0;
  int               failed = 0;
  int               total  = 0;

  always #5 clk = ~clk;

  monopulse_scheduler dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_req          (i_req),
    .i_reference    (i_reference),
    .i_error        (i_error),
    .o_grant        (o_grant),
    .o_mp_reset     (o_mp_reset),
    .o_mp_reference (o_mp_reference),
    .o_mp_error     (o_mp_error),
    .i_mp_relation  (i_mp_relation),
    .o_res_valid    (o_res_valid),
    .i_res_ready    (i_res_ready),
    .o_res_data     (o_res_data),
    .o_res_id       (o_res_id),
    .o_busy         (o_busy)
  );

  function automatic logic [DS-1:0] mag(input logic [DS-1:0] v);
    return v[DS-1] ? (~v + 64'd1) : v;
  endfunction

  // External datapath: two register stages from operands to relation.
  always_ff @(posedge clk) begin
    dp1 <= mag(o_mp_error) * mag(o_mp_reference);
    dp2 <= dp1;
  end
  assign i_mp_relation = dp2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Channel k: ref = k+1, err = -(k+2) -> relation (k+1)*(k+2).
  task automatic set_ops();
    for (int k = 0; k < NC; k++) begin
      i_reference[k*DS +: DS] = 64'(k + 1);
      i_error[k*DS +: DS]     = -64'(k + 2);
    end
  endtask

  task automatic do_reset();
    cyc();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
  endtask

  task automatic chk_head(input string tag, input int id);
    chk({tag, "_valid"}, 64'(o_res_valid), 64'd1);
    chk({tag, "_id"}, 64'(o_res_id), 64'(id));
    chk({tag, "_data"}, o_res_data, prod[id]);
  endtask

  initial begin
    logic [3:0] g;
    int         exp_ids [4];
    prod[0] = 64'd2;  prod[1] = 64'd6;  prod[2] = 64'd12; prod[3] = 64'd20;
    i_reset = 1'b1; i_flush = 1'b0; i_req = 4'b1111; i_res_ready = 1'b1;
    set_ops();

    // Reset state
    repeat (3) cyc();
    settle();
    chk("rst_mp_reset", 64'(o_mp_reset), 64'd1);
    chk("rst_grant", 64'(o_grant), 64'd0);
    cyc(); i_reset = 1'b0; i_req = 4'b0000; settle();
    chk("rst_mp_ref", o_mp_reference, 64'd0);
    chk("rst_mp_err", o_mp_error, 64'd0);
    chk("rst_valid", 64'(o_res_valid), 64'd0);
    chk("rst_data", o_res_data, 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_mp_reset_low", 64'(o_mp_reset), 64'd0);

    // Test 1: ch2 only, ref=-3, err=5
    i_reference[2*DS +: DS] = 64'hFFFF_FFFF_FFFF_FFFD;
    i_error[2*DS +: DS]     = 64'd5;
    cyc(); i_req = 4'b0100; settle();
    chk("t1_grant", 64'(o_grant), 64'h4);
    cyc(); i_req = 4'b0000; settle();
    chk("t1_mp_ref", o_mp_reference, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("t1_mp_err", o_mp_error, 64'd5);
    chk("t1_valid_t1", 64'(o_res_valid), 64'd0);
    cyc(); settle();
    chk("t1_valid_t2", 64'(o_res_valid), 64'd0);
    cyc(); settle();
    chk("t1_valid", 64'(o_res_valid), 64'd1);
    chk("t1_data", o_res_data, 64'd15);
    chk("t1_id", 64'(o_res_id), 64'd2);
    chk("t1_busy", 64'(o_busy), 64'd1);
    cyc(); settle();
    chk("t1_valid_after", 64'(o_res_valid), 64'd0);
    chk("t1_busy_after", 64'(o_busy), 64'd0);
    set_ops();

    // Test 2: all requesting, ready high: round-robin 0,1,2,3,...
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(); i_req = (i < 8) ? 4'b1111 : 4'b0000; settle();
      g = (i < 8) ? (4'b0001 << (i % 4)) : 4'b0000;
      chk("t2_grant", 64'(o_grant), 64'(g));
      if (i >= 3) chk_head("t2", (i - 3) % 4);
    end
    cyc(); settle();
    chk("t2_drained", 64'(o_res_valid), 64'd0);

    // Test 3: ready low: four grants then credit stall; one grant per pop
    for (int i = 0; i < 8; i++) begin
      cyc(); i_req = 4'b1111; i_res_ready = 1'b0; settle();
      g = (i < 4) ? (4'b0001 << i) : 4'b0000;
      chk("t3_fill_grant", 64'(o_grant), 64'(g));
    end
    chk_head("t3_full_head", 0);
    chk("t3_busy", 64'(o_busy), 64'd1);
    cyc(); i_res_ready = 1'b1; settle();
    chk("t3_c8_grant", 64'(o_grant), 64'd0);
    chk_head("t3_c8", 0);
    cyc(); i_res_ready = 1'b0; settle();
    chk("t3_c9_grant", 64'(o_grant), 64'h1);
    chk_head("t3_c9", 1);
    cyc(); settle();
    chk("t3_c10_grant", 64'(o_grant), 64'd0);
    cyc(); i_res_ready = 1'b1; settle();
    chk("t3_c11_grant", 64'(o_grant), 64'd0);
    chk_head("t3_c11", 1);
    cyc(); i_res_ready = 1'b0; settle();
    chk("t3_c12_grant", 64'(o_grant), 64'h2);
    chk_head("t3_c12", 2);
    exp_ids = '{2, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin
      cyc(); i_req = 4'b0000; i_res_ready = 1'b1; settle();
      chk_head("t3_drain", exp_ids[i]);
    end
    cyc(); settle();
    chk("t3_empty", 64'(o_res_valid), 64'd0);
    chk("t3_idle", 64'(o_busy), 64'd0);

    // Test 6: three queued + one in flight; pop and tag exit in the same cycle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(); i_req = 4'b1111; i_res_ready = 1'b0; settle();
      g = (i < 4) ? (4'b0001 << i) : 4'b0000;
      chk("t6_fill_grant", 64'(o_grant), 64'(g));
    end
    cyc(); i_res_ready = 1'b1; settle();
    chk("t6_pop_exit_grant", 64'(o_grant), 64'd0);
    chk_head("t6_pop_exit", 0);
    cyc(); i_res_ready = 1'b0; settle();
    chk("t6_regrant", 64'(o_grant), 64'h1);
    chk_head("t6_after", 1);
    exp_ids = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      cyc(); i_req = 4'b0000; i_res_ready = 1'b1; settle();
      chk_head("t6_drain", exp_ids[i]);
    end
    cyc(); settle();
    chk("t6_empty", 64'(o_res_valid), 64'd0);

    // Test 4: most-negative reference wraps
    do_reset();
    i_reference[0 +: DS] = 64'h8000_0000_0000_0000;
    i_error[0 +: DS]     = 64'd1;
    cyc(); i_req = 4'b0001; settle();
    chk("t4_grant", 64'(o_grant), 64'h1);
    cyc(); i_req = 4'b0000;
    cyc();
    cyc(); settle();
    chk("t4_valid", 64'(o_res_valid), 64'd1);
    chk("t4_data", o_res_data, 64'h8000_0000_0000_0000);
    chk("t4_id", 64'(o_res_id), 64'd0);
    set_ops();

    // Test 5: reset one cycle after a grant discards the result
    do_reset();
    cyc(); i_req = 4'b0010; settle();
    chk("t5_grant", 64'(o_grant), 64'h2);
    cyc(); i_req = 4'b0000; i_reset = 1'b1; settle();
    chk("t5_mp_reset", 64'(o_mp_reset), 64'd1);
    cyc(); i_reset = 1'b0; settle();
    chk("t5_mp_ref", o_mp_reference, 64'd0);
    chk("t5_mp_err", o_mp_error, 64'd0);
    chk("t5_busy", 64'(o_busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_valid", 64'(o_res_valid), 64'd0);
      cyc(); settle();
    end

    // Flush: queued result dropped, pointer kept
    i_req = 4'b1111; i_res_ready = 1'b0; settle();
    chk("fl_grant0", 64'(o_grant), 64'h1);
    cyc(); i_req = 4'b0000;
    cyc();
    cyc(); settle();
    chk_head("fl_queued", 0);
    cyc(); i_flush = 1'b1; i_req = 4'b1111; settle();
    chk("fl_grant_blocked", 64'(o_grant), 64'd0);
    chk("fl_mp_reset", 64'(o_mp_reset), 64'd1);
    cyc(); i_flush = 1'b0; settle();
    chk("fl_valid_gone", 64'(o_res_valid), 64'd0);
    chk("fl_busy", 64'(o_busy), 64'd0);
    chk("fl_ptr_kept", 64'(o_grant), 64'h2);
    cyc(); i_req = 4'b0000; i_res_ready = 1'b1;
    cyc(); settle();
    chk("fl_not_yet", 64'(o_res_valid), 64'd0);
    cyc(); settle();
    chk_head("fl_result", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
